// File: rtl/stage_fetch.sv
// Instruction-fetch stage of the RV32I pipeline.
// Owns the PC, runs the request/response handshake with the instruction
// cache, buffers a response the decode stage cannot take yet, and squashes
// a request that is still in flight when execute redirects the PC.
module stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_decode,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_read,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_resp,
    output logic        fetch_resp,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    // REQ : a cache read is outstanding at req_addr
    // HOLD: a response arrived but decode was stalled; it sits in hold_instr
    // KILL: a redirect arrived mid-read; the read must finish and be discarded
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] req_addr;
    logic [31:0] hold_instr;
    logic [31:0] hold_next;
    logic        issue;      // a fresh cache request starts next cycle at pc_next
    logic        if_load;    // IF/ID captures a real instruction
    logic        if_flush;   // IF/ID becomes a bubble
    logic [31:0] if_data;

    // Redirect targets are always word aligned; the low two bits are dropped.
    logic [31:0] redirect_target;
    logic [31:0] seq_pc;

    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign seq_pc          = req_addr + 32'd4;

    // The cache sees a request in every state except while parked in HOLD.
    assign inst_read = (state != HOLD);
    assign inst_addr = req_addr;

    // Next-state, next-PC and IF/ID update decisions.
    always_comb begin
        // NOTE: every signal written here is given a default first, so no
        // path through the case statement can leave one unassigned and
        // infer a latch.
        state_next = state;
        pc_next    = pc;
        hold_next  = hold_instr;
        issue      = 1'b0;
        if_load    = 1'b0;
        if_flush   = 1'b0;
        if_data    = inst_rdata;
        fetch_resp = 1'b0;

        case (state)
            REQ: begin
                if (redirect_valid) begin
                    // Flush wins over a stall; a response landing in the same
                    // cycle frees the cache so the new target issues at once.
                    pc_next  = redirect_target;
                    if_flush = 1'b1;
                    if (inst_resp) begin
                        issue = 1'b1;
                    end else begin
                        state_next = KILL;
                    end
                end else if (inst_resp) begin
                    fetch_resp = 1'b1;
                    if (load_decode) begin
                        if_load = 1'b1;
                        if_data = inst_rdata;
                        pc_next = seq_pc;
                        issue   = 1'b1;
                    end else begin
                        hold_next  = inst_rdata;
                        state_next = HOLD;
                    end
                end else if (load_decode) begin
                    // Decode advances but nothing new arrived: insert a bubble.
                    if_flush = 1'b1;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    hold_next  = '0;
                    if_flush   = 1'b1;
                    issue      = 1'b1;
                    state_next = REQ;
                end else if (load_decode) begin
                    fetch_resp = 1'b1;
                    if_load    = 1'b1;
                    if_data    = hold_instr;
                    pc_next    = seq_pc;
                    issue      = 1'b1;
                    state_next = REQ;
                end
            end

            KILL: begin
                // The newest redirect always wins; the stale data is dropped.
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (inst_resp) begin
                    issue      = 1'b1;
                    state_next = REQ;
                end
            end

            default: begin
                state_next = REQ;
            end
        endcase
    end

    // State, PC, request address, hold buffer and IF/ID register updates.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state       <= REQ;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            hold_instr  <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            hold_instr <= hold_next;
            // req_addr must stay stable while a read is outstanding, so it
            // only moves when a new request is about to issue.
            if (issue) begin
                req_addr <= pc_next;
            end
            if (if_load) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= req_addr;
                if_id_instr <= if_data;
            end else if (if_flush) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: directed scenarios followed by a
// long randomized run, all compared against a transaction-level model.
module tb_stage_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0060;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_decode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_resp;
    logic        fetch_resp;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    int checks = 0;
    int errors = 0;

    stage_fetch #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_decode    (load_decode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_read      (inst_read),
        .inst_addr      (inst_addr),
        .inst_rdata     (inst_rdata),
        .inst_resp      (inst_resp),
        .fetch_resp     (fetch_resp),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr)
    );

    always #5 clk = ~clk;

    // Transaction-level model of the fetch stage.
    //   m_cur     : address of the read the cache currently owes us
    //   m_next    : where fetching continues once the current read retires
    //   m_doomed  : the owed read was overtaken by a redirect and is discarded
    //   m_parked  : a fetched word is waiting for decode (no read outstanding)
    logic [31:0] m_cur;
    logic [31:0] m_next;
    logic        m_doomed;
    logic        m_parked;
    logic [31:0] m_park_word;
    logic        m_ifv;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifins;

    task automatic model_reset();
        m_cur       = RESET_PC;
        m_next      = RESET_PC;
        m_doomed    = 1'b0;
        m_parked    = 1'b0;
        m_park_word = '0;
        m_ifv       = 1'b0;
        m_ifpc      = '0;
        m_ifins     = NOP_INSTR;
    endtask

    task automatic model_bubble();
        m_ifv   = 1'b0;
        m_ifins = NOP_INSTR;
    endtask

    task automatic model_deliver(input logic [31:0] word);
        m_ifv   = 1'b1;
        m_ifpc  = m_cur;
        m_ifins = word;
        m_cur   = m_cur + 32'd4;
        m_next  = m_cur;
    endtask

    // Advance the model by one clock; exp_fr is the fetch pulse expected
    // during the cycle with these inputs.
    task automatic model_step(input logic ld, input logic rv, input logic [31:0] rpc,
                              input logic resp, input logic [31:0] rdata,
                              output logic exp_fr);
        logic [31:0] target;
        target = (rpc / 4) * 4;
        exp_fr = 1'b0;
        if (m_parked) begin
            if (rv) begin
                m_parked = 1'b0;
                model_bubble();
                m_cur  = target;
                m_next = target;
            end else if (ld) begin
                exp_fr   = 1'b1;
                m_parked = 1'b0;
                model_deliver(m_park_word);
            end
        end else if (m_doomed) begin
            if (rv) m_next = target;
            if (resp) begin
                m_doomed = 1'b0;
                m_cur    = m_next;
            end
        end else if (rv) begin
            model_bubble();
            m_next = target;
            if (resp) m_cur = target;
            else      m_doomed = 1'b1;
        end else if (resp) begin
            exp_fr = 1'b1;
            if (ld) begin
                model_deliver(rdata);
            end else begin
                m_parked    = 1'b1;
                m_park_word = rdata;
            end
        end else if (ld) begin
            model_bubble();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, ".inst_read"}, {31'd0, inst_read}, {31'd0, !m_parked});
        if (!m_parked) check({where, ".inst_addr"}, inst_addr, m_cur);
        check({where, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, m_ifv});
        check({where, ".if_id_pc"}, if_id_pc, m_ifpc);
        check({where, ".if_id_instr"}, if_id_instr, m_ifins);
    endtask

    // Called at a falling edge: drive inputs, check the combinational pulse,
    // let one rising edge pass and check the registered outputs.
    task automatic cycle(input logic ld, input logic rv, input logic [31:0] rpc,
                         input logic resp, input logic [31:0] rdata);
        logic exp_fr;
        load_decode    = ld;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_resp      = resp;
        inst_rdata     = rdata;
        #1;
        model_step(ld, rv, rpc, resp, rdata, exp_fr);
        check("fetch_resp", {31'd0, fetch_resp}, {31'd0, exp_fr});
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        load_decode    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_resp      = 1'b0;
        inst_rdata     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs("reset");
    endtask

    initial begin
        logic        r_ld;
        logic        r_rv;
        logic        r_resp;
        logic [31:0] r_rpc;

        // Reset state.
        apply_reset();
        check("reset.addr_const", inst_addr, 32'h0000_0060);

        // Back-to-back 1-cycle hits stream 0x60, 0x64, 0x68.
        for (int i = 0; i < 3; i++) begin
            check("stream.addr", inst_addr, 32'h0000_0060 + 32'(4 * i));
            cycle(1'b1, 1'b0, '0, 1'b1, 32'hA000_0000 + 32'(i));
            check("stream.if_id_pc", if_id_pc, 32'h0000_0060 + 32'(4 * i));
        end

        // Response at 0x64 while decode is stalled for three cycles.
        apply_reset();
        cycle(1'b1, 1'b0, '0, 1'b1, 32'hB000_0060);
        cycle(1'b0, 1'b0, '0, 1'b1, 32'hB000_0064);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        check("hold.inst_read", {31'd0, inst_read}, 32'd0);
        check("hold.if_id_pc", if_id_pc, 32'h0000_0060);
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        check("release.if_id_pc", if_id_pc, 32'h0000_0064);
        check("release.if_id_instr", if_id_instr, 32'hB000_0064);
        check("release.next_addr", inst_addr, 32'h0000_0068);

        // Slow cache: fetch at 0x70 killed by a redirect to 0x200.
        cycle(1'b1, 1'b1, 32'h0000_0070, 1'b1, '0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        check("kill.addr_held", inst_addr, 32'h0000_0070);
        cycle(1'b1, 1'b0, '0, 1'b1, 32'hDEAD_0070);
        check("kill.next_addr", inst_addr, 32'h0000_0200);
        check("kill.if_id_valid", {31'd0, if_id_valid}, 32'd0);

        // Redirect coinciding with a response; low target bits dropped.
        cycle(1'b1, 1'b1, 32'h0000_0303, 1'b1, 32'hDEAD_0200);
        check("coincident.addr", inst_addr, 32'h0000_0300);
        check("coincident.if_id_valid", {31'd0, if_id_valid}, 32'd0);

        // Two redirects during one kill: the later one wins.
        cycle(1'b1, 1'b1, 32'h0000_0100, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h0000_0180, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b1, 32'hDEAD_0300);
        check("double_redirect.addr", inst_addr, 32'h0000_0180);

        // PC wraps from 0xFFFFFFFC to 0.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, '0);
        cycle(1'b1, 1'b0, '0, 1'b1, 32'hC0DE_FFFC);
        check("wrap.addr", inst_addr, 32'h0000_0000);
        check("wrap.if_id_pc", if_id_pc, 32'hFFFF_FFFC);

        // Reset in the middle of HOLD.
        cycle(1'b0, 1'b0, '0, 1'b1, 32'hC0DE_0000);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        apply_reset();
        check("reset_hold.addr", inst_addr, 32'h0000_0060);
        check("reset_hold.if_id_valid", {31'd0, if_id_valid}, 32'd0);

        // Randomized traffic: variable cache latency, stalls and redirects.
        for (int n = 0; n < 3000; n++) begin
            r_ld   = ($urandom_range(3, 0) != 0);
            r_rv   = ($urandom_range(11, 0) == 0);
            r_rpc  = $urandom();
            r_resp = !m_parked && ($urandom_range(1, 0) == 1);
            cycle(r_ld, r_rv, r_rpc, r_resp, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
